// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
// Hazard and sequencing controller for a five-stage pipeline. It detects
// load-use hazards, squashes wrong-path work on taken branches, sequences
// RET/RTI (waiting for the popped PC to reach MEM/WB) and sequences interrupt
// entry (push PC, push flags, jump to vector).
//
// Ports
//   clk_i             processor clock, all state updates on rising edge
//   rst_i             synchronous active-high reset; forces all outputs to 0
//   int_i             external interrupt request (level, rising edge = event)
//   ex_mem_read_i     instruction in EX is a memory read
//   ex_rdst_i         destination register of instruction in EX
//   id_rsrc_i         source register of instruction in ID
//   id_rdst_i         destination register of instruction in ID
//   id_uses_rsrc_i    instruction in ID reads id_rsrc_i
//   id_uses_rdst_i    instruction in ID reads id_rdst_i
//   branch_taken_i    branch/jump resolved taken in EX this cycle
//   id_ret_i          RET decoded in ID
//   id_rti_i          RTI decoded in ID
//   stall_if_o        hold PC and IF/ID
//   stall_id_o        hold ID-stage inputs
//   flush_if_o        load a bubble into IF/ID
//   flush_id_o        load a bubble into ID/EX
//   pc_sel_o          00 PC+1, 01 branch target, 10 popped PC, 11 int vector
//   push_pc_o         one-cycle request to push PC
//   push_flags_o      one-cycle request to push flags
//   restore_flags_o   one-cycle request to restore popped flags
//   int_active_o      interrupt entry sequence in progress
// -----------------------------------------------------------------------------
module pipeline_control_unit (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       int_i,
   input  logic       ex_mem_read_i,
   input  logic [2:0] ex_rdst_i,
   input  logic [2:0] id_rsrc_i,
   input  logic [2:0] id_rdst_i,
   input  logic       id_uses_rsrc_i,
   input  logic       id_uses_rdst_i,
   input  logic       branch_taken_i,
   input  logic       id_ret_i,
   input  logic       id_rti_i,
   output logic       stall_if_o,
   output logic       stall_id_o,
   output logic       flush_if_o,
   output logic       flush_id_o,
   output logic [1:0] pc_sel_o,
   output logic       push_pc_o,
   output logic       push_flags_o,
   output logic       restore_flags_o,
   output logic       int_active_o
);

   typedef enum logic [2:0] {
      S_RUN        = 3'd0,
      S_INT_PUSHPC = 3'd1,
      S_INT_PUSHF  = 3'd2,
      S_INT_VEC    = 3'd3,
      S_RET_WAIT   = 3'd4,
      S_RET_LOAD   = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic       int_prev_q, int_prev_d;
   logic       int_pend_q, int_pend_d;
   logic [1:0] cnt_q, cnt_d;
   logic       is_rti_q, is_rti_d;

   logic       int_edge_s;
   logic       load_use_s;
   logic       ret_req_s;

   // Hazard and event decode from current-cycle inputs
   assign int_edge_s = int_i & ~int_prev_q;
   assign load_use_s = ex_mem_read_i &
                       ((id_uses_rsrc_i & (ex_rdst_i == id_rsrc_i)) |
                        (id_uses_rdst_i & (ex_rdst_i == id_rdst_i)));
   assign ret_req_s  = id_ret_i | id_rti_i;

   // State register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_RUN;
         int_prev_q <= 1'b0;
         int_pend_q <= 1'b0;
         cnt_q      <= 2'd0;
         is_rti_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         int_prev_q <= int_prev_d;
         int_pend_q <= int_pend_d;
         cnt_q      <= cnt_d;
         is_rti_q   <= is_rti_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d         = state_q;
      int_prev_d      = int_i;
      // edges arriving while already pending are simply absorbed by the OR
      int_pend_d      = int_pend_q | int_edge_s;
      cnt_d           = cnt_q;
      is_rti_d        = is_rti_q;
      stall_if_o      = 1'b0;
      stall_id_o      = 1'b0;
      flush_if_o      = 1'b0;
      flush_id_o      = 1'b0;
      pc_sel_o        = 2'b00;
      push_pc_o       = 1'b0;
      push_flags_o    = 1'b0;
      restore_flags_o = 1'b0;
      int_active_o    = 1'b0;

      if (rst_i) begin
         // reset forces a quiet interface; registers are reset in always_ff
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (branch_taken_i) begin
                  // a taken branch squashes whatever sits in IF and ID,
                  // including a RET/RTI or a load-use consumer
                  pc_sel_o   = 2'b01;
                  flush_if_o = 1'b1;
                  flush_id_o = 1'b1;
               end else if (load_use_s) begin
                  stall_if_o = 1'b1;
                  stall_id_o = 1'b1;
                  flush_id_o = 1'b1;
               end else if (ret_req_s) begin
                  flush_if_o = 1'b1;
                  state_d    = S_RET_WAIT;
                  cnt_d      = 2'd3;
                  is_rti_d   = id_rti_i;
               end else if (int_pend_q) begin
                  state_d = S_INT_PUSHPC;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_INT_PUSHPC: begin
               push_pc_o    = 1'b1;
               stall_if_o   = 1'b1;
               flush_if_o   = 1'b1;
               int_active_o = 1'b1;
               state_d      = S_INT_PUSHF;
            end
            S_INT_PUSHF: begin
               push_flags_o = 1'b1;
               stall_if_o   = 1'b1;
               flush_if_o   = 1'b1;
               int_active_o = 1'b1;
               state_d      = S_INT_VEC;
            end
            S_INT_VEC: begin
               pc_sel_o     = 2'b11;
               flush_if_o   = 1'b1;
               int_active_o = 1'b1;
               int_pend_d   = 1'b0;
               state_d      = S_RUN;
            end
            S_RET_WAIT: begin
               // wait for the popped PC to reach MEM/WB (three cycles)
               stall_if_o = 1'b1;
               flush_if_o = 1'b1;
               cnt_d      = cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  state_d = S_RET_LOAD;
               end else begin
                  state_d = S_RET_WAIT;
               end
            end
            S_RET_LOAD: begin
               pc_sel_o        = 2'b10;
               restore_flags_o = is_rti_q;
               flush_if_o      = 1'b1;
               is_rti_d        = 1'b0;
               state_d         = S_RUN;
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

endmodule
